tx_stream_scheduler: RTL and testbench



---
 rtl/tx_sched_pkg.sv | 29 ++
 rtl/tx_stream_scheduler_halt.sv | 38 +++
 rtl/tx_stream_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_tx_stream_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// tx_sched_pkg
// Shared types and constants for the TX stream scheduler.
//   state_t  : scheduler FSM states (IDLE, DATA, EDS, SKP)
//   tx_sel_t : stream-source select codes driven to the framer/mux
//   SYNC_*   : 128b/130b sync header values for data and ordered-set blocks
// -----------------------------------------------------------------------------
package tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_EDS  = 2'd2,
        ST_SKP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        SEL_IDLE_LNK = 3'd0,
        SEL_DATA     = 3'd1,
        SEL_LIDL     = 3'd2,
        SEL_EDS      = 3'd3,
        SEL_SKP      = 3'd4,
        SEL_HALT     = 3'd5
    } tx_sel_t;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;

endpackage

// File: rtl/tx_stream_scheduler_halt.sv
// -----------------------------------------------------------------------------
// tx_halt_counter
// Wrapping modulo-HALT_PERIOD counter that marks the gearbox halt cycle.
// The last count of every period is the halt cycle.
// Ports:
//   CLK, RST_L   : clock, asynchronous active-low reset
//   i_Clr        : synchronous clear (soft reset or link down)
//   i_En         : count this cycle (scheduler not idle)
//   o_Halt_Now   : current cycle is a halt cycle
// -----------------------------------------------------------------------------
module tx_halt_counter #(
    parameter int HALT_PERIOD = 64,
    parameter int HALT_CNT_W  = 6
) (
    input  logic CLK,
    input  logic RST_L,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Halt_Now
);

    localparam logic [HALT_CNT_W-1:0] LP_LAST = HALT_CNT_W'(HALT_PERIOD - 1);

    logic [HALT_CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_cnt <= '0;
        end else if (i_Clr) begin
            r_cnt <= '0;
        end else if (i_En) begin
            r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_Halt_Now = i_En && (r_cnt == LP_LAST);

endmodule

// File: rtl/tx_stream_scheduler.sv
// -----------------------------------------------------------------------------
// tx_stream_scheduler
// Read-side sequencer for the 16-deep TX interface buffer. Pops one entry per
// cycle while the link is active, inserts the gearbox halt cycle, and
// schedules SKP ordered sets (EDS token + SKP OS) at packet boundaries.
// Ports:
//   CLK, RST_L        : clock, asynchronous active-low reset
//   i_Soft_RST        : synchronous soft reset (same effect as RST_L)
//   i_Link_Active     : LTSSM in L0; low sends the scheduler to IDLE
//   i_Buf_Empty       : buffer empty flag
//   i_Buf_SOP         : head entry starts a packet
//   i_Buf_End_Valid   : head entry ends a packet
//   o_Buf_RD_EN       : pop the head entry on this edge
//   o_Tx_Sel          : stream source select (tx_sel_t)
//   o_Sync_Hdr        : sync header for the current block
//   o_Block_Start     : first cycle of a new data stream
//   o_SKP_Idx         : cycle index inside the SKP OS
//   o_Underrun        : sticky, buffer ran empty mid-packet
// -----------------------------------------------------------------------------
module tx_stream_scheduler
    import tx_sched_pkg::*;
#(
    parameter int HALT_PERIOD  = 64,
    parameter int SKP_INTERVAL = 370,
    parameter int SKP_CYCLES   = 16,
    parameter int HALT_CNT_W   = 6,
    parameter int SKP_CNT_W    = 9
) (
    input  logic       CLK,
    input  logic       RST_L,
    input  logic       i_Soft_RST,
    input  logic       i_Link_Active,
    input  logic       i_Buf_Empty,
    input  logic       i_Buf_SOP,
    input  logic       i_Buf_End_Valid,
    output logic       o_Buf_RD_EN,
    output logic [2:0] o_Tx_Sel,
    output logic [1:0] o_Sync_Hdr,
    output logic       o_Block_Start,
    output logic [3:0] o_SKP_Idx,
    output logic       o_Underrun
);

    localparam logic [SKP_CNT_W-1:0] LP_SKP_DUE  = SKP_CNT_W'(SKP_INTERVAL);
    localparam logic [3:0]           LP_SKP_LAST = 4'(SKP_CYCLES - 1);

    state_t                r_state;
    logic                  r_in_packet;
    logic [SKP_CNT_W-1:0]  r_skp_timer;
    logic [3:0]            r_skp_idx;
    logic                  r_first_flag;
    logic                  r_underrun;

    state_t                w_state_nxt;
    logic                  w_in_packet_nxt;
    logic [SKP_CNT_W-1:0]  w_skp_timer_nxt;
    logic [3:0]            w_skp_idx_nxt;
    logic                  w_first_flag_nxt;
    logic                  w_underrun_nxt;

    logic                  w_halt;
    logic                  w_skp_pending;
    logic                  w_data_slot;
    logic                  w_go_eds;
    logic                  w_pop;
    logic                  w_underrun_set;
    tx_sel_t               w_sel;

    // Halt counter runs on every non-idle cycle, halt cycles included.
    tx_halt_counter #(
        .HALT_PERIOD (HALT_PERIOD),
        .HALT_CNT_W  (HALT_CNT_W)
    ) u_halt (
        .CLK        (CLK),
        .RST_L      (RST_L),
        .i_Clr      (i_Soft_RST | ~i_Link_Active),
        .i_En       (r_state != ST_IDLE),
        .o_Halt_Now (w_halt)
    );

    // Datapath qualifiers shared by next-state and output logic.
    assign w_skp_pending  = (r_skp_timer == LP_SKP_DUE);
    assign w_data_slot    = (r_state == ST_DATA) && !w_halt;
    // A due SKP waits until the current packet has been fully popped.
    assign w_go_eds       = w_data_slot && w_skp_pending && !r_in_packet;
    assign w_pop          = w_data_slot && !w_go_eds && !i_Buf_Empty;
    assign w_underrun_set = w_data_slot && !w_go_eds && i_Buf_Empty && r_in_packet;

    // State register
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_state      <= ST_IDLE;
            r_in_packet  <= 1'b0;
            r_skp_timer  <= '0;
            r_skp_idx    <= '0;
            r_first_flag <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (i_Soft_RST) begin
            r_state      <= ST_IDLE;
            r_in_packet  <= 1'b0;
            r_skp_timer  <= '0;
            r_skp_idx    <= '0;
            r_first_flag <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_packet  <= w_in_packet_nxt;
            r_skp_timer  <= w_skp_timer_nxt;
            r_skp_idx    <= w_skp_idx_nxt;
            r_first_flag <= w_first_flag_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    // Next-state logic. Halt cycles hold every sequencing register.
    always_comb begin
        w_state_nxt      = r_state;
        w_in_packet_nxt  = r_in_packet;
        w_skp_timer_nxt  = r_skp_timer;
        w_skp_idx_nxt    = r_skp_idx;
        w_first_flag_nxt = r_first_flag;
        w_underrun_nxt   = r_underrun | w_underrun_set;

        case (r_state)
            ST_IDLE: begin
                if (i_Link_Active) begin
                    w_state_nxt      = ST_DATA;
                    w_first_flag_nxt = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_data_slot) begin
                    w_first_flag_nxt = 1'b0;
                    if (w_go_eds) begin
                        w_state_nxt     = ST_EDS;
                        w_skp_timer_nxt = '0;
                    end else begin
                        // Timer saturates at the due value until the SKP goes out.
                        if (!w_skp_pending) begin
                            w_skp_timer_nxt = r_skp_timer + 1'b1;
                        end
                        if (w_pop) begin
                            if (i_Buf_End_Valid) begin
                                w_in_packet_nxt = 1'b0;
                            end else if (i_Buf_SOP) begin
                                w_in_packet_nxt = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_EDS: begin
                if (!w_halt) begin
                    w_state_nxt   = ST_SKP;
                    w_skp_idx_nxt = '0;
                end
            end
            ST_SKP: begin
                if (!w_halt) begin
                    if (r_skp_idx == LP_SKP_LAST) begin
                        w_state_nxt      = ST_DATA;
                        w_skp_idx_nxt    = '0;
                        w_first_flag_nxt = 1'b1;
                    end else begin
                        w_skp_idx_nxt = r_skp_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Link loss overrides everything except the sticky underrun flag.
        if (!i_Link_Active) begin
            w_state_nxt      = ST_IDLE;
            w_in_packet_nxt  = 1'b0;
            w_skp_timer_nxt  = '0;
            w_skp_idx_nxt    = '0;
            w_first_flag_nxt = 1'b0;
        end
    end

    // Output logic
    always_comb begin
        w_sel         = SEL_IDLE_LNK;
        o_Buf_RD_EN   = 1'b0;
        o_Sync_Hdr    = SYNC_OS;
        o_Block_Start = 1'b0;
        o_SKP_Idx     = '0;

        case (r_state)
            ST_DATA: begin
                o_Sync_Hdr = SYNC_DATA;
                if (w_halt) begin
                    w_sel = SEL_HALT;
                end else begin
                    o_Block_Start = r_first_flag;
                    if (w_pop) begin
                        w_sel       = SEL_DATA;
                        o_Buf_RD_EN = 1'b1;
                    end else begin
                        w_sel = SEL_LIDL;
                    end
                end
            end
            ST_EDS: begin
                o_Sync_Hdr = SYNC_DATA;
                w_sel      = w_halt ? SEL_HALT : SEL_EDS;
            end
            ST_SKP: begin
                o_Sync_Hdr = SYNC_OS;
                o_SKP_Idx  = r_skp_idx;
                w_sel      = w_halt ? SEL_HALT : SEL_SKP;
            end
            default: begin
                w_sel = SEL_IDLE_LNK;
            end
        endcase
    end

    assign o_Tx_Sel   = w_sel;
    assign o_Underrun = r_underrun;

endmodule

// File: tb/tb_tx_stream_scheduler.sv
module tb_tx_stream_scheduler;

    localparam int HP = 64;
    localparam int SI = 370;
    localparam int SC = 16;

    logic       CLK;
    logic       RST_L;
    logic       i_Soft_RST;
    logic       i_Link_Active;
    logic       i_Buf_Empty;
    logic       i_Buf_SOP;
    logic       i_Buf_End_Valid;
    logic       o_Buf_RD_EN;
    logic [2:0] o_Tx_Sel;
    logic [1:0] o_Sync_Hdr;
    logic       o_Block_Start;
    logic [3:0] o_SKP_Idx;
    logic       o_Underrun;

    tx_stream_scheduler #(
        .HALT_PERIOD  (HP),
        .SKP_INTERVAL (SI),
        .SKP_CYCLES   (SC),
        .HALT_CNT_W   (6),
        .SKP_CNT_W    (9)
    ) dut (
        .CLK             (CLK),
        .RST_L           (RST_L),
        .i_Soft_RST      (i_Soft_RST),
        .i_Link_Active   (i_Link_Active),
        .i_Buf_Empty     (i_Buf_Empty),
        .i_Buf_SOP       (i_Buf_SOP),
        .i_Buf_End_Valid (i_Buf_End_Valid),
        .o_Buf_RD_EN     (o_Buf_RD_EN),
        .o_Tx_Sel        (o_Tx_Sel),
        .o_Sync_Hdr      (o_Sync_Hdr),
        .o_Block_Start   (o_Block_Start),
        .o_SKP_Idx       (o_SKP_Idx),
        .o_Underrun      (o_Underrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;

    // Buffer contents as seen at the read side
    bit q_sop[$];
    bit q_eop[$];
    int g_rem = 0;

    // Behavioural model: link-up flag, active-cycle count (halt = every HP-th),
    // streaming cycles since last SKP, OS position (-1 stream, 0 EDS, k>0 SKP k-1)
    int m_up, m_active, m_since, m_os, m_new, m_mid, m_und;
    int e_rd, e_sel, e_sync, e_bs, e_idx, e_und;
    int s_rd, s_sel, s_sync, s_bs, s_idx, s_und;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit s, input bit e);
        q_sop.push_back(s);
        q_eop.push_back(e);
    endtask

    task automatic push_gen();
        bit s;
        bit e;
        if (g_rem == 0) begin
            g_rem = $urandom_range(1, 12);
            s = 1'b1;
        end else begin
            s = 1'b0;
        end
        g_rem--;
        e = (g_rem == 0);
        push(s, e);
    endtask

    task automatic model_reset();
        m_up = 0; m_active = 0; m_since = 0; m_os = -1; m_new = 0; m_mid = 0; m_und = 0;
    endtask

    task automatic model_out(input bit emp);
        bit halt;
        e_und = m_und; e_rd = 0; e_sel = 0; e_sync = 1; e_bs = 0; e_idx = 0;
        if (m_up != 0) begin
            halt = ((m_active % HP) == HP - 1);
            if (m_os >= 1) begin
                e_sync = 1;
                e_idx  = m_os - 1;
                e_sel  = halt ? 5 : 4;
            end else begin
                e_sync = 2;
                if (halt) e_sel = 5;
                else if (m_os == 0) e_sel = 3;
                else begin
                    e_bs = m_new;
                    if (m_since >= SI && m_mid == 0) e_sel = 2;
                    else if (!emp) begin e_sel = 1; e_rd = 1; end
                    else e_sel = 2;
                end
            end
        end
    endtask

    task automatic model_adv(input bit link, input bit srst, input bit emp, input bit sop, input bit eop);
        bit halt;
        bit stream;
        if (srst) begin
            model_reset();
            return;
        end
        halt   = (m_up != 0) && ((m_active % HP) == HP - 1);
        stream = (m_up != 0) && !halt && (m_os < 0) && !(m_since >= SI && m_mid == 0);
        if (stream && emp && m_mid != 0) m_und = 1;
        if (!link) begin
            m_up = 0; m_active = 0; m_since = 0; m_os = -1; m_new = 0; m_mid = 0;
            return;
        end
        if (m_up == 0) begin
            m_up = 1; m_active = 0; m_new = 1; m_since = 0; m_os = -1; m_mid = 0;
            return;
        end
        m_active++;
        if (halt) return;
        if (m_os == 0) m_os = 1;
        else if (m_os >= 1) begin
            if (m_os == SC) begin m_os = -1; m_new = 1; end
            else m_os++;
        end else begin
            m_new = 0;
            if (m_since >= SI && m_mid == 0) begin
                m_os = 0; m_since = 0;
            end else begin
                if (m_since < SI) m_since++;
                if (!emp) begin
                    if (eop) m_mid = 0;
                    else if (sop) m_mid = 1;
                end
            end
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance at posedge
    task automatic run_cycle(input bit link, input bit srst);
        bit emp;
        bit sop;
        bit eop;
        emp = (q_sop.size() == 0);
        sop = emp ? 1'b0 : q_sop[0];
        eop = emp ? 1'b0 : q_eop[0];
        i_Link_Active   = link;
        i_Soft_RST      = srst;
        i_Buf_Empty     = emp;
        i_Buf_SOP       = sop;
        i_Buf_End_Valid = eop;
        @(negedge CLK);
        s_rd = int'(o_Buf_RD_EN); s_sel = int'(o_Tx_Sel); s_sync = int'(o_Sync_Hdr);
        s_bs = int'(o_Block_Start); s_idx = int'(o_SKP_Idx); s_und = int'(o_Underrun);
        model_out(emp);
        chk("rd_en", s_rd, e_rd);
        chk("tx_sel", s_sel, e_sel);
        chk("sync_hdr", s_sync, e_sync);
        chk("block_start", s_bs, e_bs);
        chk("skp_idx", s_idx, e_idx);
        chk("underrun", s_und, e_und);
        @(posedge CLK);
        if (s_rd != 0) begin
            chk("pop_nonempty", emp ? 0 : 1, 1);
            if (!emp) begin
                void'(q_sop.pop_front());
                void'(q_eop.pop_front());
            end
        end
        model_adv(link, srst, emp, sop, eop);
        #1;
    endtask

    initial begin
        int halts[$];
        int pops, nskp, neds, ph, done;
        int down;
        bit lk, sr;

        RST_L = 1'b0; i_Soft_RST = 1'b0; i_Link_Active = 1'b0;
        i_Buf_Empty = 1'b1; i_Buf_SOP = 1'b0; i_Buf_End_Valid = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RST_L = 1'b1;

        // Reset state
        run_cycle(0, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_sync", s_sync, 1);
        chk("rst_rd", s_rd, 0);
        chk("rst_und", s_und, 0);

        // Link up with a 5-entry packet preloaded
        push(1, 0); push(0, 0); push(0, 0); push(0, 0); push(0, 1);
        run_cycle(1, 0);
        for (int c = 1; c <= 6; c++) begin
            run_cycle(1, 0);
            if (c == 1) chk("t1_block_start", s_bs, 1);
            if (c <= 5) begin
                chk("t1_rd", s_rd, 1);
                chk("t1_sel_data", s_sel, 1);
            end else begin
                chk("t1_sel_lidl", s_sel, 2);
                chk("t1_rd_end", s_rd, 0);
            end
        end

        // Continuous traffic: halts at active cycles 63 and 127
        run_cycle(0, 0);
        run_cycle(1, 0);
        for (int k = 0; k < 130; k++) begin
            while (q_sop.size() < 4) push_gen();
            run_cycle(1, 0);
            if (s_sel == 5) halts.push_back(k);
        end
        chk("t2_halt_count", halts.size(), 2);
        if (halts.size() == 2) begin
            chk("t2_halt0", halts[0], 63);
            chk("t2_halt1", halts[1], 127);
        end

        // SKP due while 3 entries of a packet remain
        run_cycle(0, 0);
        q_sop.delete(); q_eop.delete(); g_rem = 0;
        push(1, 0);
        for (int i = 1; i < 372; i++) push(0, 0);
        push(0, 1);
        push(1, 0); push(0, 0); push(0, 0); push(0, 1);
        run_cycle(1, 0);
        pops = 0; nskp = 0; neds = 0; ph = 0; done = 0;
        for (int k = 0; k < 700 && done == 0; k++) begin
            run_cycle(1, 0);
            if (ph == 0) begin
                if (s_rd != 0) pops++;
                if (s_sel == 3) begin
                    neds++;
                    ph = 1;
                    chk("t3_pops_before_eds", pops, 373);
                end
            end else if (ph == 1) begin
                if (s_sel == 3) neds++;
                if (s_sel == 4) begin
                    chk("t3_skp_idx", s_idx, nskp);
                    chk("t3_skp_sync", s_sync, 1);
                    nskp++;
                    if (nskp == SC) ph = 2;
                end
            end else if (s_sel != 5) begin
                chk("t3_block_start", s_bs, 1);
                chk("t3_resume_data", s_sel, 1);
                done = 1;
            end
        end
        chk("t3_done", done, 1);
        chk("t3_skp_cycles", nskp, SC);
        chk("t3_eds_cycles", neds, 1);

        // Underrun: buffer runs dry after the SOP entry
        for (int k = 0; k < 20 && q_sop.size() != 0; k++) run_cycle(1, 0);
        run_cycle(1, 0);
        chk("t4_und_before", s_und, 0);
        push(1, 0);
        for (int k = 0; k < 5 && q_sop.size() != 0; k++) run_cycle(1, 0);
        repeat (3) run_cycle(1, 0);
        chk("t4_und_set", s_und, 1);
        push(0, 0); push(0, 1);
        repeat (4) run_cycle(1, 0);
        chk("t4_und_sticky", s_und, 1);

        // Link drop while SKP_Idx is 7
        done = 0;
        for (int k = 0; k < 1200; k++) begin
            if (m_up != 0 && m_os == 8 && (m_active % HP) != HP - 1) begin
                done = 1;
                break;
            end
            run_cycle(1, 0);
        end
        chk("t5_reached", done, 1);
        run_cycle(0, 0);
        chk("t5_sel_skp", s_sel, 4);
        chk("t5_idx7", s_idx, 7);
        run_cycle(1, 0);
        chk("t5_idle_sel", s_sel, 0);
        chk("t5_idle_rd", s_rd, 0);
        run_cycle(1, 0);
        chk("t5_relink_bs", s_bs, 1);

        // Soft reset mid-packet
        push(1, 0);
        for (int i = 0; i < 6; i++) push(0, 0);
        push(0, 1);
        repeat (3) run_cycle(1, 0);
        chk("t6_und_pre", s_und, 1);
        run_cycle(1, 1);
        run_cycle(1, 0);
        chk("t6_sel", s_sel, 0);
        chk("t6_rd", s_rd, 0);
        chk("t6_und", s_und, 0);
        chk("t6_sync", s_sync, 1);
        chk("t6_bs", s_bs, 0);

        // Randomized traffic with occasional link loss and soft reset
        down = 0;
        for (int k = 0; k < 4000; k++) begin
            if (down > 0) begin
                down--;
                lk = 1'b0;
            end else begin
                lk = 1'b1;
                if ($urandom_range(0, 1499) == 0) down = $urandom_range(1, 3);
            end
            sr = ($urandom_range(0, 899) == 0);
            if (q_sop.size() < 16 && $urandom_range(0, 99) < 65) push_gen();
            run_cycle(lk, sr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
